// File: rtl/wb_bus_arbiter_rr_pkg.sv
// Shared definitions for the round-robin Wishbone bus arbiter.
package wb_bus_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_HANDOFF = 2'd2
  } arb_state_t;

  localparam int MAX_CORES        = 4;
  localparam int DEFAULT_MAX_HOLD = 256;
  localparam int DEFAULT_CNT_W    = 9;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: rotate requests by the pointer, take the
// lowest set bit, rotate the index back. Zero latency, no backpressure.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_vld
);

  logic [NUM_REQ-1:0] w_rot;
  logic [SEL_W-1:0]   w_idx_rot;

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rot[i] = i_req[SEL_W'(i) + i_ptr];
    end
  end

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    w_idx_rot = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_idx_rot = SEL_W'(i);
    end
  end

  always_comb begin
    o_vld           = |i_req;
    o_idx           = w_idx_rot + i_ptr;
    o_onehot        = '0;
    o_onehot[o_idx] = o_vld;
  end

endmodule

// File: rtl/wb_bus_arbiter_rr.sv
// Round-robin owner arbitration for the shared Wishbone master bus, with
// hold-time preemption (never mid-beat) and sticky spurious-ACK detection.
module wb_bus_arbiter_rr
  import wb_bus_arbiter_rr_pkg::*;
#(
  parameter int NUM_REQ  = MAX_CORES,
  parameter int SEL_W    = $clog2(NUM_REQ),
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic [NUM_REQ-1:0] iRequest,
  input  logic [NUM_REQ-1:0] iStb,
  input  logic               ACK_I,
  output logic [NUM_REQ-1:0] oGrant,
  output logic [SEL_W-1:0]   oBusSelect,
  output logic               STB_O,
  output logic [NUM_REQ-1:0] oAck,
  output logic               oBusy,
  output logic               oSpuriousAck
);

  localparam bit               PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(MAX_HOLD);

  arb_state_t         r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_ptr, w_ptr_nxt, w_sel_nxt, w_pick_idx;
  logic [NUM_REQ-1:0] w_pick_oh, w_grant_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               w_pick_vld, w_busy_nxt;
  logic               w_owner_req, w_owner_stb, w_others, w_preempt, w_release;

  rr_priority_picker #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W)) u_picker (
    .i_req    (iRequest),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_vld    (w_pick_vld)
  );

  assign w_owner_req = iRequest[oBusSelect];
  assign w_owner_stb = iStb[oBusSelect];
  assign w_others    = |(iRequest & ~oGrant);
  assign w_preempt   = PREEMPT_EN && (r_cnt >= HOLD_LIM) && w_others && !w_owner_stb;
  assign w_release   = !w_owner_req || w_preempt;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) r_state <= ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:    if (w_pick_vld) w_state_nxt = ARB_GRANT;
      ARB_GRANT:   if (w_release)  w_state_nxt = ARB_HANDOFF;
      ARB_HANDOFF: w_state_nxt = w_pick_vld ? ARB_GRANT : ARB_IDLE;
      default:     w_state_nxt = ARB_IDLE;
    endcase
  end

  // Next values of the registered outputs; the counter only runs while granted.
  always_comb begin
    w_grant_nxt = '0;
    w_sel_nxt   = oBusSelect;
    w_busy_nxt  = 1'b0;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = '0;
    case (r_state)
      ARB_IDLE, ARB_HANDOFF: begin
        if (w_pick_vld) begin
          w_grant_nxt = w_pick_oh;
          w_sel_nxt   = w_pick_idx;
          w_busy_nxt  = 1'b1;
        end
      end
      ARB_GRANT: begin
        if (w_release) begin
          w_ptr_nxt = oBusSelect + SEL_W'(1);
        end else begin
          w_grant_nxt = oGrant;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      oGrant       <= '0;
      oBusSelect   <= '0;
      oBusy        <= 1'b0;
      r_ptr        <= '0;
      r_cnt        <= '0;
      oSpuriousAck <= 1'b0;
    end else begin
      oGrant     <= w_grant_nxt;
      oBusSelect <= w_sel_nxt;
      oBusy      <= w_busy_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      if (ACK_I && !(|oGrant)) oSpuriousAck <= 1'b1;
    end
  end

  assign STB_O = |(iStb & oGrant);
  assign oAck  = oGrant & {NUM_REQ{ACK_I}};

endmodule

// File: doc/wb_bus_arbiter_rr.md
Name: wb_bus_arbiter_rr

Overview:
- Round-robin arbiter that shares the single outbound Wishbone master bus among up to NUM_REQ Theia cores.
- Sits between the cores' CYC_O/STB_O requests and the top-level output muxes.
  - Drives per-core GNT_I.
  - Drives the mux select.
  - Routes the shared ACK_I only to the bus owner.
- Adds hold-time preemption and spurious-ACK detection.

Parameters:
- NUM_REQ, 4, number of requesting cores (power of two, ≥2).
- SEL_W, 2, width of encoded select; SEL_W = log2(NUM_REQ).
- MAX_HOLD, 256, cycles an owner may keep the bus before it can be preempted; 0 disables preemption.
- CNT_W, 9, hold-counter width; must represent MAX_HOLD.

Ports:
- CLK_I  in  1  clock; all state on the rising edge.
- RST_I  in  1  reset; asynchronous, active-low.
- iRequest  in  NUM_REQ  per-core bus request (core CYC_O).
- iStb  in  NUM_REQ  per-core strobe (core STB_O).
- ACK_I  in  1  shared slave acknowledge.
- oGrant  out  NUM_REQ  one-hot grant (core GNT_I), registered.
- oBusSelect  out  SEL_W  encoded owner index for output muxes, registered.
- STB_O  out  1  gated strobe: iStb[owner] while a grant is active, else 0.
- oAck  out  NUM_REQ  oAck[i] = ACK_I & oGrant[i] (combinational).
- oBusy  out  1  high while any grant is active.
- oSpuriousAck  out  1  sticky; set by ACK_I with no grant active.

Behaviour:
- Reset (RST_I low, async):
  - State IDLE.
  - oGrant = 0, oBusSelect = 0, oBusy = 0, oSpuriousAck = 0.
  - Priority pointer = 0; hold counter = 0.
  - STB_O and oAck are 0 because oGrant is 0.
- States: IDLE, GRANT, HANDOFF.
- Priority pick: first i with iRequest[i] = 1, searching from the pointer upward, wrapping NUM_REQ-1 → 0.
- IDLE:
  - If any iRequest is high: register the pick into oGrant/oBusSelect, set oBusy, go to GRANT.
  - Grant appears exactly 1 cycle after the request is sampled.
  - No request: stay in IDLE; oBusSelect keeps its last value.
- GRANT:
  - Hold counter increments each cycle and saturates at 2^CNT_W-1.
  - Owner release: iRequest[owner] = 0 → HANDOFF; oGrant cleared, pointer = owner+1 mod NUM_REQ.
  - Preemption: MAX_HOLD ≠ 0, counter ≥ MAX_HOLD, another request pending, and iStb[owner] = 0 → HANDOFF with the same pointer update.
    - Never preempt while iStb[owner] = 1; a beat in flight always completes.
  - Otherwise hold the grant.
- HANDOFF:
  - Exactly one dead cycle with oGrant = 0 and oBusy = 0; oBusSelect holds the old owner.
  - Hold counter cleared.
  - Next cycle: re-pick as in IDLE using the updated pointer. Request present → GRANT; none → IDLE.
  - Bus-turnaround latency between owners is 2 cycles.
- A preempted core that still requests is eligible again, at lowest priority.
- Simultaneous release by the owner and new requests: release wins; the new pick happens from HANDOFF.
- ACK_I while oGrant = 0: discarded (all oAck = 0) and oSpuriousAck set; it clears only on reset.
- Mid-operation reset drops the grant immediately (async); cores must abandon the cycle.
- iRequest bits at index ≥ active cores are tied 0 by the integrator; no special handling.

Decomposition:
- Shared definitions (aDefinitions.v):
  - State encodings ARB_IDLE/ARB_GRANT/ARB_HANDOFF.
  - MAX_CORES, from which NUM_REQ defaults.
  - Default MAX_HOLD.
- One sub-module: rr_priority_picker. Combinational; inputs request vector + pointer; outputs one-hot pick, encoded index, valid. Implemented by request rotation, priority encode, and rotate-back.
- FSM, counter and pointer live in the top.

Test Plan:
- Single requester: iRequest = 0001 at cycle 0 → oGrant = 0001, oBusSelect = 0 at cycle 1. Release at cycle 10 → oGrant = 0 at cycle 11; IDLE at cycle 12.
- Round robin: iRequest = 1111, each owner releases after 3 cycles → grant order 0,1,2,3,0, with one dead cycle between owners.
- Wraparound: pointer = 3 after core 2 releases, iRequest = 1001 → core 3 granted, then core 0.
- Preemption:
  - MAX_HOLD = 8; core 1 holds with iStb toggling; core 2 requests at cycle 2.
  - At hold count 8 with iStb[1] = 1 → no preemption.
  - First cycle afterwards with iStb[1] = 0 → HANDOFF, then oGrant = 0100.
- ACK routing: owner core 2, ACK_I pulse → oAck = 0100 only. ACK_I while idle → oAck = 0000 and oSpuriousAck = 1, persisting until RST_I low.
- Async reset mid-GRANT: RST_I low between clock edges → oGrant, oBusy, oBusSelect = 0 immediately. After release, a 0010 request is granted one cycle later.
